perceptron_trainer: RTL and testbench
=====================================

# perceptron_trainer

Online training controller for the two-input perceptron datapath. It stores a small set of labelled samples and presents them one per step to an external perceptron instance. It waits out the datapath pipeline, compares the perceptron output to the target, and applies the perceptron learning rule to the weights and bias it drives. It sits between the host/config logic and the perceptron, owning the perceptron's x/w/b inputs.

## Interface
- N, 8, operand width (x, w); bias is 2N bits
- DEPTH, 4, sample store entries (power of 2)
- LAT, 4, perceptron input-to-output latency in clk_in cycles
- MAX_EPOCH, 16, epoch limit
- BSTEP, 1, bias update magnitude
- clk_in  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ld_valid  in  1  write sample ld_idx; honoured only in IDLE/DONE
- ld_idx  in  log2(DEPTH)  sample slot
- ld_x1, ld_x2  in  N  sample inputs
- ld_target  in  1  sample label
- start  in  1  begin training; honoured only in IDLE/DONE
- n_samp  in  log2(DEPTH)+1  samples per epoch, latched at start; 0 or >DEPTH means DEPTH
- init_w1, init_w2  in  N  initial weights, latched at start
- init_b  in  2N  initial bias, latched at start
- p_x1, p_x2, p_w1, p_w2  out  N  perceptron drive, registered
- p_b  out  2N  perceptron bias drive, registered
- p_out  in  1  perceptron decision
- busy  out  1  training in progress
- done  out  1  training finished; held until next start
- converged  out  1  last completed epoch had zero errors
- epoch  out  log2(MAX_EPOCH)+1  epochs completed

## Operation
- States: IDLE, ISSUE, WAIT, UPDATE, EPOCH_END, DONE.
- IDLE/DONE + start: latch n_samp and init values into the weight registers. Clear epoch, the sample index, the error flag and done. Go to ISSUE.
- ISSUE (1 cycle): load p_x1/p_x2 from sample[idx] and p_w1/p_w2/p_b from the weight registers. Go to WAIT.
- WAIT (LAT cycles, down-counter): all p_* held stable, then go to UPDATE.
- UPDATE (1 cycle): compare p_out to target. On match, no change.
  - target=1, p_out=0: w1+=x1, w2+=x2, b+=BSTEP, each saturating at all-ones.
  - target=0, p_out=1: w1-=x1, w2-=x2, b-=BSTEP, each saturating at 0.
  - On mismatch, set the epoch error flag.
  - If idx = n_samp-1, go to EPOCH_END; otherwise increment idx and go to ISSUE.
- EPOCH_END (1 cycle): increment epoch; converged = !error flag; clear error flag and idx.
  - Go to DONE if early stop fires (see Configuration) or epoch reaches MAX_EPOCH; otherwise go to ISSUE.
- DONE: done=1, busy=0; weight registers and p_* hold the final values.
- All arithmetic is unsigned. Updates are computed one bit wider, then clamped.
- ld_valid and start while busy are ignored. In IDLE/DONE, start takes priority; a same-cycle ld_valid write also lands.

## Timing
- Reset values: p_* = 0, busy = 0, done = 0, converged = 0, epoch = 0, state IDLE. The sample store is not reset.
- rst mid-training aborts immediately to reset values.
- Latency:
  - start edge to busy=1: next cycle.
  - Per sample: LAT+2 cycles.
  - Per epoch: n_samp*(LAT+2)+1 cycles.
- p_out is consumed only in UPDATE, i.e. LAT edges after the p_* change.

## Configuration
- PERCEPTRON_TRAINER_EARLY_STOP_EN defined: EPOCH_END goes to DONE as soon as an epoch has zero errors.
- Not defined: always runs exactly MAX_EPOCH epochs. converged still reflects the last epoch.

## Structure
- Shared package perceptron_pkg holds:
  - the state enum;
  - the default N/LAT constants;
  - the saturating width helper constants.
- One sub-module, sat_addsub: parameterised width, add/sub select, clamps to [0, 2^W-1]. Instantiated three times (w1, w2, b).
- Sample store: a DEPTH-entry register array inside the trainer.

## Test plan
- Reset: hold rst mid-WAIT -> all outputs return to reset values within the same cycle; later start trains normally.
- Single sample (20,20,t=1), init 0, n_samp=1, behavioural perceptron (threshold 320):
  - epoch 1 updates to w=(20,20), b=1;
  - epoch 2 has no error;
  - done with converged=1, epoch=2 (early stop on).
- Subtract saturation: sample (100,0,t=0), init w1=5 -> p_out=1, w1 becomes 0 (not wrap); w2 unchanged; b=init_b-1.
- Add saturation: init w1=250, sample (10,0,t=1) with a perceptron model forced to output 0 -> w1=255.
- Epoch limit: MAX_EPOCH=3, samples that never converge -> done after exactly 3*(n_samp*(LAT+2)+1) cycles, epoch=3, converged=0.
- Ignored controls: pulse start and ld_valid while busy -> no restart, sample store unchanged, cycle count unchanged.

Source files
------------

// File: rtl/perceptron_pkg.sv
// ---------------------------------------------------------------------------
// perceptron_pkg
// Shared definitions for the perceptron training controller:
//   - state_t : trainer FSM state encoding
//   - DEF_N   : default operand width for samples and weights
//   - DEF_LAT : default perceptron input-to-output latency
//   - SAT_GUARD : extra bit carried by saturating add/sub to detect overflow
// ---------------------------------------------------------------------------
package perceptron_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        UPDATE,
        EPOCH_END,
        DONE
    } state_t;

    localparam int unsigned DEF_N     = 8;
    localparam int unsigned DEF_LAT   = 4;
    localparam int unsigned SAT_GUARD = 1;

endpackage

// File: rtl/perceptron_trainer_sat_addsub.sv
// ---------------------------------------------------------------------------
// sat_addsub
// Unsigned saturating adder/subtractor. The result is computed SAT_GUARD bits
// wider than the operands; the guard bit flags carry (add) or borrow (sub),
// and the output is then clamped to [0, 2^W-1].
// Ports:
//   a   in  W  minuend / augend
//   b   in  W  subtrahend / addend
//   sub in  1  1: a-b clamped at 0, 0: a+b clamped at all-ones
//   y   out W  clamped result
// ---------------------------------------------------------------------------
module sat_addsub
    import perceptron_pkg::*;
#(
    parameter int unsigned W = DEF_N
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] y
);

    logic [W+SAT_GUARD-1:0] ext;

    always_comb begin
        if (sub) begin
            ext = {{SAT_GUARD{1'b0}}, a} - {{SAT_GUARD{1'b0}}, b};
        end else begin
            ext = {{SAT_GUARD{1'b0}}, a} + {{SAT_GUARD{1'b0}}, b};
        end
        // Guard bit set means carry out on add or borrow on sub.
        if (ext[W]) begin
            y = sub ? '0 : '1;
        end else begin
            y = ext[W-1:0];
        end
    end

endmodule

// File: rtl/perceptron_trainer.sv
// ---------------------------------------------------------------------------
// perceptron_trainer
// Online training controller for a two-input perceptron. Holds DEPTH labelled
// samples, presents one per step to an external perceptron, waits LAT cycles
// for its decision, and applies the perceptron learning rule to the weights
// and bias it drives.
// Optional feature macro: PERCEPTRON_TRAINER_EARLY_STOP_EN
//   defined     : training stops after the first error-free epoch
//   not defined : training always runs MAX_EPOCH epochs
// Ports:
//   clk_in, rst              clock, async active-high reset
//   ld_valid/ld_idx/ld_x1/ld_x2/ld_target  sample store write (IDLE/DONE only)
//   start, n_samp            begin training, samples per epoch (0/>DEPTH=DEPTH)
//   init_w1/init_w2/init_b   initial weights and bias, latched at start
//   p_x1/p_x2/p_w1/p_w2/p_b  registered perceptron drive
//   p_out                    perceptron decision
//   busy/done/converged/epoch  training status
// ---------------------------------------------------------------------------
module perceptron_trainer
    import perceptron_pkg::*;
#(
    parameter int unsigned N         = DEF_N,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned LAT       = DEF_LAT,
    parameter int unsigned MAX_EPOCH = 16,
    parameter int unsigned BSTEP     = 1
) (
    input  logic                         clk_in,
    input  logic                         rst,
    input  logic                         ld_valid,
    input  logic [$clog2(DEPTH)-1:0]     ld_idx,
    input  logic [N-1:0]                 ld_x1,
    input  logic [N-1:0]                 ld_x2,
    input  logic                         ld_target,
    input  logic                         start,
    input  logic [$clog2(DEPTH):0]       n_samp,
    input  logic [N-1:0]                 init_w1,
    input  logic [N-1:0]                 init_w2,
    input  logic [2*N-1:0]               init_b,
    output logic [N-1:0]                 p_x1,
    output logic [N-1:0]                 p_x2,
    output logic [N-1:0]                 p_w1,
    output logic [N-1:0]                 p_w2,
    output logic [2*N-1:0]               p_b,
    input  logic                         p_out,
    output logic                         busy,
    output logic                         done,
    output logic                         converged,
    output logic [$clog2(MAX_EPOCH):0]   epoch
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned EW = $clog2(MAX_EPOCH) + 1;
    localparam int unsigned CW = $clog2(LAT + 1);

    localparam logic [IW:0]    DEPTH_V   = (IW+1)'(DEPTH);
    localparam logic [IW-1:0]  IDX_MAX   = IW'(DEPTH - 1);
    localparam logic [EW-1:0]  EPOCH_MAX = EW'(MAX_EPOCH);
    localparam logic [CW-1:0]  CNT_INIT  = CW'(LAT - 1);
    localparam logic [2*N-1:0] BSTEP_V   = (2*N)'(BSTEP);

    state_t         state;
    logic [IW-1:0]  idx;
    logic [IW-1:0]  last;
    logic [CW-1:0]  cnt;
    logic           err;
    logic [N-1:0]   w1;
    logic [N-1:0]   w2;
    logic [2*N-1:0] b;

    logic [N-1:0]   mem_x1 [DEPTH];
    logic [N-1:0]   mem_x2 [DEPTH];
    logic           mem_t  [DEPTH];

    logic           idle_like;
    logic           tgt;
    logic           mismatch;
    logic [IW:0]    n_m1;
    logic [IW-1:0]  last_nxt;
    logic [EW-1:0]  epoch_nxt;
    logic           stop;
    logic [N-1:0]   w1_upd;
    logic [N-1:0]   w2_upd;
    logic [2*N-1:0] b_upd;

    always_comb begin
        idle_like = (state == IDLE) || (state == DONE);
        tgt       = mem_t[idx];
        mismatch  = (p_out != tgt);
        n_m1      = n_samp - 1'b1;
        if ((n_samp == '0) || (n_samp > DEPTH_V)) begin
            last_nxt = IDX_MAX;
        end else begin
            last_nxt = n_m1[IW-1:0];
        end
        epoch_nxt = epoch + 1'b1;
`ifdef PERCEPTRON_TRAINER_EARLY_STOP_EN
        stop = !err || (epoch_nxt == EPOCH_MAX);
`else
        stop = (epoch_nxt == EPOCH_MAX);
`endif
    end

    // A mismatch with target=1 means the output was too low (add);
    // with target=0 it was too high (subtract).
    sat_addsub #(.W(N)) u_sat_w1 (.a(w1), .b(p_x1), .sub(!tgt), .y(w1_upd));
    sat_addsub #(.W(N)) u_sat_w2 (.a(w2), .b(p_x2), .sub(!tgt), .y(w2_upd));
    sat_addsub #(.W(2*N)) u_sat_b (.a(b), .b(BSTEP_V), .sub(!tgt), .y(b_upd));

    // Sample store: not reset, writable only while not training.
    always_ff @(posedge clk_in) begin
        if (ld_valid && idle_like) begin
            mem_x1[ld_idx] <= ld_x1;
            mem_x2[ld_idx] <= ld_x2;
            mem_t[ld_idx]  <= ld_target;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            last      <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            w1        <= '0;
            w2        <= '0;
            b         <= '0;
            p_x1      <= '0;
            p_x2      <= '0;
            p_w1      <= '0;
            p_w2      <= '0;
            p_b       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            converged <= 1'b0;
            epoch     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        w1    <= init_w1;
                        w2    <= init_w2;
                        b     <= init_b;
                        last  <= last_nxt;
                        epoch <= '0;
                        idx   <= '0;
                        err   <= 1'b0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    p_x1  <= mem_x1[idx];
                    p_x2  <= mem_x2[idx];
                    p_w1  <= w1;
                    p_w2  <= w2;
                    p_b   <= b;
                    cnt   <= CNT_INIT;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state <= UPDATE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                UPDATE: begin
                    if (mismatch) begin
                        w1  <= w1_upd;
                        w2  <= w2_upd;
                        b   <= b_upd;
                        err <= 1'b1;
                    end
                    if (idx == last) begin
                        state <= EPOCH_END;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ISSUE;
                    end
                end
                EPOCH_END: begin
                    epoch     <= epoch_nxt;
                    converged <= !err;
                    err       <= 1'b0;
                    idx       <= '0;
                    // Publish the post-update weights so DONE shows the final
                    // values; the next ISSUE reloads the same values anyway.
                    p_w1      <= w1;
                    p_w2      <= w2;
                    p_b       <= b;
                    if (stop) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        state <= ISSUE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_perceptron_trainer.sv
// ---------------------------------------------------------------------------
// tb_perceptron_trainer
// Self-checking bench for perceptron_trainer: directed table of training
// scenarios with hand-derived results, hand sequences for reset and ignored
// controls, and randomized trainings checked against an epoch-level model.
// Honors PERCEPTRON_TRAINER_EARLY_STOP_EN when computing expected epochs.
// ---------------------------------------------------------------------------
module tb_perceptron_trainer;

    localparam int LAT  = 4;
    localparam int MAXE = 3;
`ifdef PERCEPTRON_TRAINER_EARLY_STOP_EN
    localparam bit ES = 1'b1;
`else
    localparam bit ES = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_valid;
    logic [1:0]  ld_idx;
    logic [7:0]  ld_x1, ld_x2;
    logic        ld_target;
    logic        start;
    logic [2:0]  n_samp;
    logic [7:0]  init_w1, init_w2;
    logic [15:0] init_b;
    logic [7:0]  p_x1, p_x2, p_w1, p_w2;
    logic [15:0] p_b;
    logic        p_out;
    logic        busy, done, converged;
    logic [2:0]  epoch;

    always #5 clk = ~clk;

    perceptron_trainer #(
        .N(8), .DEPTH(4), .LAT(LAT), .MAX_EPOCH(MAXE), .BSTEP(1)
    ) dut (
        .clk_in(clk), .rst(rst),
        .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_x1(ld_x1), .ld_x2(ld_x2),
        .ld_target(ld_target),
        .start(start), .n_samp(n_samp),
        .init_w1(init_w1), .init_w2(init_w2), .init_b(init_b),
        .p_x1(p_x1), .p_x2(p_x2), .p_w1(p_w1), .p_w2(p_w2), .p_b(p_b),
        .p_out(p_out),
        .busy(busy), .done(done), .converged(converged), .epoch(epoch)
    );

    // Behavioural perceptron: mode 0 thresholds at 320, mode 1 always says 0.
    int mode;
    function automatic int perc(input int m, input int x1, input int x2,
                                input int w1, input int w2, input int b);
        if (m == 1) return 0;
        return ((w1 * x1 + w2 * x2 + b) >= 320) ? 1 : 0;
    endfunction

    logic [LAT-1:0] pipe = '0;
    always @(posedge clk)
        pipe <= {pipe[LAT-2:0], perc(mode, p_x1, p_x2, p_w1, p_w2, p_b) != 0};
    assign p_out = pipe[LAT-1];

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input int tag, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d expected %0d", name, tag, act, exp);
        end
    endtask

    // Mirror of what the bench has loaded into the sample store.
    int s_x1[4], s_x2[4], s_t[4];

    function automatic int clampi(input int v, input int hi);
        return (v < 0) ? 0 : ((v > hi) ? hi : v);
    endfunction

    // Epoch-level reference of the learning rule.
    function automatic void ref_train(input int ns, input int m, input int iw1, input int iw2,
                                      input int ib, output int w1, output int w2, output int b,
                                      output int ep, output int conv);
        int n, errs, o;
        n = (ns == 0 || ns > 4) ? 4 : ns;
        w1 = iw1; w2 = iw2; b = ib; ep = 0; conv = 0;
        for (int e = 0; e < MAXE; e++) begin
            errs = 0;
            for (int i = 0; i < n; i++) begin
                o = perc(m, s_x1[i], s_x2[i], w1, w2, b);
                if (o != s_t[i]) begin
                    errs++;
                    if (s_t[i] == 1) begin
                        w1 = clampi(w1 + s_x1[i], 255);
                        w2 = clampi(w2 + s_x2[i], 255);
                        b  = clampi(b + 1, 65535);
                    end else begin
                        w1 = clampi(w1 - s_x1[i], 255);
                        w2 = clampi(w2 - s_x2[i], 255);
                        b  = clampi(b - 1, 65535);
                    end
                end
            end
            ep++;
            conv = (errs == 0) ? 1 : 0;
            if (ES && errs == 0) break;
        end
    endfunction

    task automatic load_sample(input int i, input int x1, input int x2, input int t);
        @(negedge clk);
        ld_valid = 1'b1; ld_idx = 2'(i); ld_x1 = 8'(x1); ld_x2 = 8'(x2); ld_target = t[0];
        s_x1[i] = x1; s_x2[i] = x2; s_t[i] = t;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic check_reset_state(input int tag);
        check("rst_p_x1", tag, p_x1, 0);
        check("rst_p_x2", tag, p_x2, 0);
        check("rst_p_w1", tag, p_w1, 0);
        check("rst_p_w2", tag, p_w2, 0);
        check("rst_p_b", tag, p_b, 0);
        check("rst_busy", tag, busy, 0);
        check("rst_done", tag, done, 0);
        check("rst_converged", tag, converged, 0);
        check("rst_epoch", tag, epoch, 0);
    endtask

    // Starts a training run and counts edges after the start edge until done.
    task automatic do_run(input int ns, input int iw1, input int iw2, input int ib,
                          input bit disturb, input int tag, output int cyc);
        bit to;
        @(negedge clk);
        n_samp = 3'(ns); init_w1 = 8'(iw1); init_w2 = 8'(iw2); init_b = 16'(ib);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", tag, busy, 1);
        check("done_after_start", tag, done, 0);
        cyc = 0;
        to = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(posedge clk);
            cyc++;
            #1;
            if (done) begin
                to = 1'b0;
                break;
            end
            if (disturb && cyc == 5) begin
                start = 1'b1; n_samp = 3'd1;
                ld_valid = 1'b1; ld_idx = 2'd0; ld_x1 = 8'd99; ld_x2 = 8'd99; ld_target = 1'b0;
            end
            if (disturb && cyc == 6) begin
                start = 1'b0; ld_valid = 1'b0;
            end
        end
        if (to) begin
            n_cmp++;
            n_fail++;
            $display("FAIL done_timeout[%0d]: got no done after %0d cycles expected done", tag, cyc);
        end
    endtask

    task automatic check_result(input int tag, input int ns, input int ew1, input int ew2,
                                input int eb, input int eep, input int econv, input int cyc);
        int n;
        n = (ns == 0 || ns > 4) ? 4 : ns;
        check("w1", tag, p_w1, ew1);
        check("w2", tag, p_w2, ew2);
        check("b", tag, p_b, eb);
        check("epoch", tag, epoch, eep);
        check("converged", tag, converged, econv);
        check("busy_at_done", tag, busy, 0);
        check("cycles", tag, cyc, eep * (n * (LAT + 2) + 1));
    endtask

    typedef struct packed {
        logic [3:0][7:0] x1;
        logic [3:0][7:0] x2;
        logic [3:0]      t;
        logic [2:0]      ns;
        logic            md;
        logic [7:0]      iw1;
        logic [7:0]      iw2;
        logic [15:0]     ib;
        logic [7:0]      ew1;
        logic [7:0]      ew2;
        logic [15:0]     eb;
        logic [3:0]      ep_es;
        logic            conv;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        int cyc, ew1, ew2, eb, eep, econv, ns, iw1, iw2, ib;

        // add saturation: forced-0 perceptron, w1 clamps at 255
        vecs[0] = '{x1: {8'd0, 8'd0, 8'd0, 8'd10}, x2: '0, t: 4'b0001, ns: 3'd1, md: 1'b1,
                    iw1: 8'd250, iw2: 8'd3, ib: 16'd0,
                    ew1: 8'd255, ew2: 8'd3, eb: 16'd3, ep_es: 4'd3, conv: 1'b0};
        // epoch limit: never converges, bias clamps at all-ones
        vecs[1] = '{x1: {8'd0, 8'd0, 8'd3, 8'd1}, x2: {8'd0, 8'd0, 8'd4, 8'd2}, t: 4'b0011,
                    ns: 3'd2, md: 1'b1, iw1: 8'd0, iw2: 8'd0, ib: 16'hFFFE,
                    ew1: 8'd12, ew2: 8'd18, eb: 16'hFFFF, ep_es: 4'd3, conv: 1'b0};
        // single sample learns in one epoch
        vecs[2] = '{x1: {8'd0, 8'd0, 8'd0, 8'd20}, x2: {8'd0, 8'd0, 8'd0, 8'd20}, t: 4'b0001,
                    ns: 3'd1, md: 1'b0, iw1: 8'd0, iw2: 8'd0, ib: 16'd0,
                    ew1: 8'd20, ew2: 8'd20, eb: 16'd1, ep_es: 4'd2, conv: 1'b1};
        // subtract saturation: w1 and b clamp at 0
        vecs[3] = '{x1: {8'd0, 8'd0, 8'd0, 8'd100}, x2: '0, t: 4'b0000, ns: 3'd1, md: 1'b0,
                    iw1: 8'd5, iw2: 8'd7, ib: 16'd0,
                    ew1: 8'd0, ew2: 8'd7, eb: 16'd0, ep_es: 4'd2, conv: 1'b1};

        rst = 1'b1; ld_valid = 1'b0; ld_idx = '0; ld_x1 = '0; ld_x2 = '0; ld_target = 1'b0;
        start = 1'b0; n_samp = '0; init_w1 = '0; init_w2 = '0; init_b = '0; mode = 0;
        repeat (2) @(negedge clk);
        check_reset_state(0);
        @(negedge clk);
        rst = 1'b0;

        for (int r = 0; r < 4; r++) begin
            v = vecs[r];
            for (int i = 0; i < 4; i++) load_sample(i, v.x1[i], v.x2[i], int'(v.t[i]));
            mode = int'(v.md);
            do_run(v.ns, v.iw1, v.iw2, v.ib, 1'b0, r, cyc);
            eep = ES ? int'(v.ep_es) : MAXE;
            check_result(r, v.ns, v.ew1, v.ew2, v.eb, eep, v.conv, cyc);
        end

        // Controls pulsed while busy must not restart or write the store;
        // a second run on the same store must give identical results.
        v = vecs[1];
        for (int i = 0; i < 4; i++) load_sample(i, v.x1[i], v.x2[i], int'(v.t[i]));
        mode = 1;
        do_run(v.ns, v.iw1, v.iw2, v.ib, 1'b1, 10, cyc);
        check_result(10, v.ns, v.ew1, v.ew2, v.eb, MAXE, 0, cyc);
        do_run(v.ns, v.iw1, v.iw2, v.ib, 1'b0, 11, cyc);
        check_result(11, v.ns, v.ew1, v.ew2, v.eb, MAXE, 0, cyc);

        // Reset asserted mid-WAIT while converged=1 from an earlier run.
        v = vecs[2];
        for (int i = 0; i < 4; i++) load_sample(i, v.x1[i], v.x2[i], int'(v.t[i]));
        mode = 0;
        do_run(1, 0, 0, 0, 1'b0, 12, cyc);
        check("converged_before_rst", 12, converged, 1);
        @(negedge clk);
        n_samp = 3'd1; init_w1 = 8'd9; init_w2 = 8'd9; init_b = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("p_x1_loaded", 13, p_x1, 20);
        rst = 1'b1;
        #1;
        check_reset_state(13);
        @(negedge clk);
        rst = 1'b0;

        // Randomized trainings against the reference model.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 4; i++)
                load_sample(i, $urandom_range(31), $urandom_range(31), $urandom_range(1));
            ns  = $urandom_range(7);
            iw1 = $urandom_range(15);
            iw2 = $urandom_range(15);
            ib  = $urandom_range(300);
            mode = 0;
            ref_train(ns, 0, iw1, iw2, ib, ew1, ew2, eb, eep, econv);
            do_run(ns, iw1, iw2, ib, 1'b0, 20 + t, cyc);
            check_result(20 + t, ns, ew1, ew2, eb, eep, econv, cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
